// File: rtl/iic_ctrl_fsm_if.sv
// Bus-side handshake for the I2C slave control FSM: detector strobes and
// synchronised SDA into the slave, ACK drive enable back out.
interface iic_ctrl_fsm_if;
  logic iic_start_det;
  logic iic_stop_det;
  logic iic_scl_rise;
  logic sda_in;
  logic iic_sda_oe;

  modport master (
    output iic_start_det,
    output iic_stop_det,
    output iic_scl_rise,
    output sda_in,
    input  iic_sda_oe
  );

  modport slave (
    input  iic_start_det,
    input  iic_stop_det,
    input  iic_scl_rise,
    input  sda_in,
    output iic_sda_oe
  );
endinterface

// File: rtl/iic_ctrl_fsm.sv
// I2C slave frame controller: tracks CMD/address/data slots, decodes the
// device select, and drives ACK and frame-reset controls.
module iic_ctrl_fsm #(
  parameter logic [3:0] DEV_CODE    = 4'b1010,
  parameter logic [2:0] IIC_IDLE    = 3'b000,
  parameter logic [2:0] IIC_CMD     = 3'b001,
  parameter logic [2:0] IIC_ADDR_HB = 3'b010,
  parameter logic [2:0] IIC_ADDR_LB = 3'b011,
  parameter logic [2:0] IIC_DAT_RD  = 3'b100,
  parameter logic [2:0] IIC_WAIT    = 3'b101,
  parameter logic [2:0] IIC_DAT_WR  = 3'b110
) (
  input  logic                 iic_clk_c,
  input  logic                 iic_sys_rst_n,
  iic_ctrl_fsm_if.slave        bus,
  input  logic [2:0]           iic_dev_sel,
  output logic [2:0]           iic_curr_state,
  output logic [3:0]           iic_bit_cnt,
  output logic                 iic_bitcnt_is_0,
  output logic                 iic_bitcnt_is_1,
  output logic                 iic_bitcnt_is_2,
  output logic [1:0]           iic_byte_cnt,
  output logic                 iic_frm_rst_n,
  output logic                 iic_rw
);

  logic [2:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [1:0] r_byte_cnt;
  logic [7:0] r_cmd_sr;
  logic       r_rw;
  logic       r_sda_oe;
  logic       r_frm_rst_n;

  logic [2:0] w_nxt_state;
  logic [3:0] w_nxt_cnt;
  logic [1:0] w_nxt_byte;
  logic [7:0] w_nxt_sr;
  logic       w_nxt_rw;
  logic       w_nxt_oe;
  logic       w_active;
  logic       w_match_cur;
  logic       w_match_nxt;

  function automatic logic cmd_match(input logic [7:0] c, input logic [2:0] sel);
    return (c[7:4] == DEV_CODE) && (c[3:1] == sel);
  endfunction

  assign w_active    = (r_state != IIC_IDLE) && (r_state != IIC_WAIT);
  assign w_match_cur = cmd_match(r_cmd_sr, iic_dev_sel);
  assign w_match_nxt = cmd_match(w_nxt_sr, iic_dev_sel);

  // START beats STOP, and both beat a coincident SCL strobe.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_bit_cnt;
    w_nxt_byte  = r_byte_cnt;
    w_nxt_sr    = r_cmd_sr;
    w_nxt_rw    = r_rw;
    if (bus.iic_start_det) begin
      w_nxt_state = IIC_CMD;
      w_nxt_cnt   = 4'd8;
      w_nxt_byte  = 2'd0;
      w_nxt_sr    = 8'd0;
      w_nxt_rw    = 1'b0;
    end else if (bus.iic_stop_det) begin
      w_nxt_state = IIC_IDLE;
      w_nxt_cnt   = 4'd8;
    end else if (bus.iic_scl_rise && w_active) begin
      if (r_bit_cnt != 4'd0) begin
        w_nxt_cnt = r_bit_cnt - 4'd1;
        if (r_state == IIC_CMD) begin
          w_nxt_sr = {r_cmd_sr[6:0], bus.sda_in};
          if (r_bit_cnt == 4'd1) w_nxt_rw = bus.sda_in;
        end
      end else begin
        w_nxt_cnt = 4'd8;
        case (r_state)
          IIC_CMD: begin
            if (!w_match_cur)     w_nxt_state = IIC_WAIT;
            else if (r_cmd_sr[0]) w_nxt_state = IIC_DAT_RD;
            else                  w_nxt_state = IIC_ADDR_HB;
          end
          IIC_ADDR_HB: w_nxt_state = IIC_ADDR_LB;
          IIC_ADDR_LB: w_nxt_state = IIC_DAT_WR;
          IIC_DAT_WR: begin
            w_nxt_state = IIC_DAT_WR;
            w_nxt_byte  = r_byte_cnt + 2'd1;
          end
          IIC_DAT_RD: begin
            w_nxt_state = bus.sda_in ? IIC_WAIT : IIC_DAT_RD;
            w_nxt_byte  = r_byte_cnt + 2'd1;
          end
          default: w_nxt_state = IIC_IDLE;
        endcase
      end
    end
  end

  // ACK drive is registered, so it is decided from the state being entered.
  assign w_nxt_oe = (w_nxt_cnt == 4'd0) &&
                    ((w_nxt_state == IIC_ADDR_HB) ||
                     (w_nxt_state == IIC_ADDR_LB) ||
                     (w_nxt_state == IIC_DAT_WR)  ||
                     ((w_nxt_state == IIC_CMD) && w_match_nxt));

  always_ff @(posedge iic_clk_c or negedge iic_sys_rst_n) begin
    if (!iic_sys_rst_n) begin
      r_state     <= IIC_IDLE;
      r_bit_cnt   <= 4'd8;
      r_byte_cnt  <= 2'd0;
      r_cmd_sr    <= 8'd0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_frm_rst_n <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_bit_cnt   <= w_nxt_cnt;
      r_byte_cnt  <= w_nxt_byte;
      r_cmd_sr    <= w_nxt_sr;
      r_rw        <= w_nxt_rw;
      r_sda_oe    <= w_nxt_oe;
      r_frm_rst_n <= ~(bus.iic_start_det | bus.iic_stop_det);
    end
  end

  assign iic_curr_state  = r_state;
  assign iic_bit_cnt     = r_bit_cnt;
  assign iic_bitcnt_is_0 = (r_bit_cnt == 4'd0);
  assign iic_bitcnt_is_1 = (r_bit_cnt == 4'd1);
  assign iic_bitcnt_is_2 = (r_bit_cnt == 4'd2);
  assign iic_byte_cnt    = r_byte_cnt;
  assign iic_frm_rst_n   = r_frm_rst_n;
  assign iic_rw          = r_rw;
  assign bus.iic_sda_oe  = r_sda_oe;

endmodule

// File: doc/iic_ctrl_fsm.md
IIC_CTRL_FSM -- requirements
Module: iic_ctrl_fsm

Interface
REQ-001 The block SHALL have these parameters, one per line:
- DEV_CODE, default 4'b1010, device-type code matched against command byte bits [7:4].
- IIC_IDLE, default 3'b000, idle state code.
- IIC_CMD, default 3'b001, command state code.
- IIC_ADDR_HB, default 3'b010, address high byte state code.
- IIC_ADDR_LB, default 3'b011, address low byte state code.
- IIC_DAT_RD, default 3'b100, data read state code.
- IIC_WAIT, default 3'b101, wait state code.
- IIC_DAT_WR, default 3'b110, data write state code.
REQ-002 The block SHALL have these ports, one per line:
- iic_clk_c  in  1  clock, all flops on rising edge.
- iic_sys_rst_n  in  1  reset, asynchronous, active-low.
- iic_start_det  in  1  1-cycle pulse, START or repeated START seen on bus.
- iic_stop_det  in  1  1-cycle pulse, STOP seen on bus.
- iic_scl_rise  in  1  1-cycle strobe, SDA sample point.
- sda_in  in  1  synchronised SDA.
- iic_dev_sel  in  3  chip-select pins, matched against command bits [3:1].
- iic_curr_state  out  3  current FSM state.
- iic_bit_cnt  out  4  bits remaining in the current 9-bit slot; 0 = ACK bit.
- iic_bitcnt_is_0, iic_bitcnt_is_1, iic_bitcnt_is_2  out  1 each  decodes of iic_bit_cnt.
- iic_byte_cnt  out  2  data bytes completed in this frame.
- iic_frm_rst_n  out  1  active-low frame reset, to address generator and shifters.
- iic_rw  out  1  latched R/W bit; 1 = read.
- iic_sda_oe  out  1  1 = slave drives SDA low (ACK).

Function
REQ-003 All outputs SHALL be registered except the iic_bitcnt_is_* decodes, which SHALL be combinational from iic_bit_cnt.
REQ-004 iic_bit_cnt SHALL load 8 on every state entry.
REQ-005 In every state other than IDLE and WAIT, iic_bit_cnt SHALL decrement by 1 on each iic_scl_rise while nonzero.
REQ-006 An iic_scl_rise with iic_bit_cnt==0 SHALL complete the slot and cause a state transition or re-entry, reloading iic_bit_cnt to 8.
REQ-007 The command byte SHALL shift MSB first on each iic_scl_rise while iic_bit_cnt>0; bit 0 SHALL be latched into iic_rw.
REQ-008 From IDLE, iic_start_det SHALL move the FSM to CMD.
REQ-009 From CMD at the end of the slot:
- bits [7:4]==DEV_CODE, bits [3:1]==iic_dev_sel and rw=0 SHALL go to ADDR_HB.
- a match with rw=1 SHALL go to DAT_RD.
- a mismatch SHALL go to WAIT.
REQ-010 From ADDR_HB the FSM SHALL go to ADDR_LB, and from ADDR_LB to DAT_WR.
REQ-011 DAT_WR SHALL re-enter itself at each slot end.
REQ-012 In DAT_RD, if sda_in is 0 at the iic_scl_rise with iic_bit_cnt==0 (master ACK), the FSM SHALL re-enter DAT_RD; if it is 1 (master NACK), it SHALL go to WAIT.
REQ-013 WAIT SHALL hold, with iic_bit_cnt frozen at 8, until a START or STOP.
REQ-014 iic_stop_det SHALL force IDLE from any state.
REQ-015 iic_start_det SHALL force CMD from any state, including repeated START mid-byte.
REQ-016 If iic_start_det and iic_stop_det occur in the same cycle, START SHALL win.
REQ-017 If START or STOP coincides with an iic_scl_rise, the START or STOP SHALL take priority and the strobe SHALL be ignored.
REQ-018 iic_sda_oe SHALL be 1 exactly while iic_bit_cnt==0 in CMD with a match, ADDR_HB, ADDR_LB or DAT_WR; it SHALL be 0 otherwise, always 0 in DAT_RD, and never 1 on a CMD mismatch.
REQ-019 iic_byte_cnt SHALL increment by 1 at each slot end in DAT_WR or DAT_RD.
REQ-020 iic_byte_cnt SHALL wrap 3->0 and clear on START.
REQ-021 iic_frm_rst_n SHALL pulse 0 for exactly 1 cycle, the cycle after any iic_start_det or iic_stop_det, and be 1 otherwise.
REQ-022 The CMD shift register and iic_rw SHALL clear on iic_start_det.

Reset
REQ-023 While iic_sys_rst_n=0, the block SHALL hold: iic_curr_state=IDLE, iic_bit_cnt=8, iic_byte_cnt=0, iic_rw=0, iic_sda_oe=0, iic_frm_rst_n=1, CMD shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort immediately to the REQ-023 values, without a frm_rst pulse.
REQ-025 After reset release, the block SHALL stay in IDLE until the first iic_start_det.

Verification
REQ-026 Write addr: START, cmd 8'hA0 (iic_dev_sel=0), 8'h12, 8'h34 -> states CMD, ADDR_HB, ADDR_LB, DAT_WR; iic_sda_oe=1 on each of the 3 ACK slots.
REQ-027 Page write of 5 bytes, then STOP -> iic_byte_cnt sequence 1,2,3,0,1; IDLE after STOP; one frm_rst pulse after STOP.
REQ-028 Read: START, 8'hA1, data ACK, ACK, NACK -> DAT_RD, DAT_RD, DAT_RD then WAIT; iic_sda_oe stays 0 during all data slots.
REQ-029 Mismatch: START, cmd 8'hA2 with iic_dev_sel=0 -> WAIT, no ACK; a following STOP gives IDLE.
REQ-030 Repeated START after 3 bits of ADDR_LB -> CMD, iic_bit_cnt=8, iic_byte_cnt=0, one frm_rst pulse.
REQ-031 START and STOP in the same cycle -> CMD; iic_sys_rst_n low mid-DAT_WR -> all outputs at the REQ-023 values immediately.
